// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur game-flow controller:
// player state encoding, obstacle type codes, seven-segment glyph codes
// and the three-glyph words shown in each state.
package dino_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_JUMP = 3'd2,
        ST_DUCK = 3'd3,
        ST_OVER = 3'd4
    } dino_state_t;

    localparam logic OBS_LOW  = 1'b0;   // cleared by jumping
    localparam logic OBS_HIGH = 1'b1;   // cleared by ducking

    localparam logic [3:0] G_S     = 4'h0;
    localparam logic [3:0] G_T     = 4'h1;
    localparam logic [3:0] G_P     = 4'h2;
    localparam logic [3:0] G_J     = 4'h3;
    localparam logic [3:0] G_U     = 4'h4;
    localparam logic [3:0] G_M     = 4'h5;
    localparam logic [3:0] G_L     = 4'h6;
    localparam logic [3:0] G_O     = 4'h7;
    localparam logic [3:0] G_W     = 4'h8;
    localparam logic [3:0] G_E     = 4'h9;
    localparam logic [3:0] G_N     = 4'hA;
    localparam logic [3:0] G_D     = 4'hB;
    localparam logic [3:0] G_BLANK = 4'hF;

    localparam logic [11:0] WORD_STOP = {G_S, G_T, G_P};
    localparam logic [11:0] WORD_RUN  = {G_BLANK, G_BLANK, G_BLANK};
    localparam logic [11:0] WORD_JUMP = {G_J, G_U, G_M};
    localparam logic [11:0] WORD_DUCK = {G_L, G_O, G_W};
    localparam logic [11:0] WORD_OVER = {G_E, G_N, G_D};

    // Glyph word for the display in a given state.
    function automatic logic [11:0] state_word(input dino_state_t st);
        logic [11:0] w;
        w = WORD_STOP;
        case (st)
            ST_IDLE: w = WORD_STOP;
            ST_RUN:  w = WORD_RUN;
            ST_JUMP: w = WORD_JUMP;
            ST_DUCK: w = WORD_DUCK;
            ST_OVER: w = WORD_OVER;
            default: w = WORD_STOP;
        endcase
        return w;
    endfunction

    // One-hot LED pattern {over, duck, jump, run, stop}.
    function automatic logic [4:0] state_leds(input dino_state_t st);
        logic [4:0] l;
        l = 5'b00001;
        case (st)
            ST_IDLE: l = 5'b00001;
            ST_RUN:  l = 5'b00010;
            ST_JUMP: l = 5'b00100;
            ST_DUCK: l = 5'b01000;
            ST_OVER: l = 5'b10000;
            default: l = 5'b00001;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/dino_btn_sync.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// rising-edge detector producing a single-cycle pulse per press.
module dino_btn_sync (
    input  logic clk_in,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync_d;

    // Synchronize the button and keep one delayed copy for edge detection.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= i_btn;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_sync_d;

endmodule

// File: rtl/dino_game_sequencer.sv
// Game-flow controller for the dinosaur board: divided game tick, button
// arbitration, obstacle handshake, saturating score and display word.
// Define DINO_HISCORE_EN to keep a best-score register; otherwise hiscore
// is tied to zero.
//
//  state | meaning
//  IDLE  | stopped, "STP" shown, waiting for start
//  RUN   | running, display blank, jump/duck accepted
//  JUMP  | airborne for JUMP_TICKS ticks, clears low obstacles
//  DUCK  | ducking for DUCK_TICKS ticks, clears high obstacles
//  OVER  | game over, "END" shown, start returns to IDLE
module dino_game_sequencer
    import dino_pkg::*;
#(
    parameter int TICK_DIV   = 20000000,
    parameter int JUMP_TICKS = 4,
    parameter int DUCK_TICKS = 4
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        btn_start,
    input  logic        btn_jump,
    input  logic        btn_duck,
    input  logic        obs_valid,
    input  logic        obs_type,
    output logic        obs_ack,
    output logic        game_tick,
    output logic [2:0]  state_o,
    output logic [3:0]  score,
    output logic [3:0]  hiscore,
    output logic [11:0] i_select,
    output logic        led_stop,
    output logic        led_run,
    output logic        led_jump,
    output logic        led_duck,
    output logic        led_over
);

    logic [26:0]  r_tick_cnt;
    logic         r_game_tick;
    logic         r_pend_start;
    logic         r_pend_jump;
    logic         r_pend_duck;
    dino_state_t  r_state;
    logic [3:0]   r_timer;
    logic [3:0]   r_score;
    logic         r_obs_ack;
    logic [11:0]  r_select;
    logic [4:0]   r_leds;

    logic         w_edge_start;
    logic         w_edge_jump;
    logic         w_edge_duck;
    dino_state_t  w_state_nxt;
    logic [3:0]   w_timer_nxt;
    logic [3:0]   w_score_nxt;
    logic         w_ack_nxt;
    logic         w_obs_match;

    dino_btn_sync u_sync_start (.clk_in(clk_in), .reset_n(reset_n), .i_btn(btn_start), .o_pulse(w_edge_start));
    dino_btn_sync u_sync_jump  (.clk_in(clk_in), .reset_n(reset_n), .i_btn(btn_jump),  .o_pulse(w_edge_jump));
    dino_btn_sync u_sync_duck  (.clk_in(clk_in), .reset_n(reset_n), .i_btn(btn_duck),  .o_pulse(w_edge_duck));

    // Tick divider: strobe for one cycle after the counter wraps.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_tick_cnt  <= 27'd0;
            r_game_tick <= 1'b0;
        end else if (r_tick_cnt == 27'(TICK_DIV - 1)) begin
            r_tick_cnt  <= 27'd0;
            r_game_tick <= 1'b1;
        end else begin
            r_tick_cnt  <= r_tick_cnt + 27'd1;
            r_game_tick <= 1'b0;
        end
    end

    // Sticky press flags; a tick consumes them, but an edge landing on the
    // tick cycle itself was not seen by that tick and is kept.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_pend_start <= 1'b0;
            r_pend_jump  <= 1'b0;
            r_pend_duck  <= 1'b0;
        end else if (r_game_tick) begin
            r_pend_start <= w_edge_start;
            r_pend_jump  <= w_edge_jump;
            r_pend_duck  <= w_edge_duck;
        end else begin
            r_pend_start <= r_pend_start | w_edge_start;
            r_pend_jump  <= r_pend_jump  | w_edge_jump;
            r_pend_duck  <= r_pend_duck  | w_edge_duck;
        end
    end

    assign w_obs_match = ((r_state == ST_JUMP) && (obs_type == OBS_LOW)) ||
                         ((r_state == ST_DUCK) && (obs_type == OBS_HIGH));

    // Next-state decision, evaluated only on tick cycles; a mismatched
    // obstacle overrides any button or timer transition.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_score_nxt = r_score;
        w_ack_nxt   = 1'b0;
        if (r_game_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pend_start) begin
                        w_state_nxt = ST_RUN;
                        w_score_nxt = 4'd0;
                    end
                end
                ST_RUN: begin
                    if (obs_valid) begin
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = ST_OVER;
                    end else if (r_pend_jump) begin
                        w_state_nxt = ST_JUMP;
                        w_timer_nxt = 4'(JUMP_TICKS - 1);
                    end else if (r_pend_duck) begin
                        w_state_nxt = ST_DUCK;
                        w_timer_nxt = 4'(DUCK_TICKS - 1);
                    end
                end
                ST_JUMP, ST_DUCK: begin
                    if (r_timer == 4'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_timer_nxt = r_timer - 4'd1;
                    end
                    if (obs_valid) begin
                        w_ack_nxt = 1'b1;
                        if (w_obs_match) begin
                            w_score_nxt = (r_score == 4'hF) ? 4'hF : r_score + 4'd1;
                        end else begin
                            w_state_nxt = ST_OVER;
                        end
                    end
                end
                ST_OVER: begin
                    if (r_pend_start) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register with display word and LEDs registered alongside it.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= 4'd0;
            r_score   <= 4'd0;
            r_obs_ack <= 1'b0;
            r_select  <= WORD_STOP;
            r_leds    <= 5'b00001;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_score   <= w_score_nxt;
            r_obs_ack <= w_ack_nxt;
            r_select  <= state_word(w_state_nxt);
            r_leds    <= state_leds(w_state_nxt);
        end
    end

`ifdef DINO_HISCORE_EN
    logic [3:0] r_hiscore;

    // Capture the best score on the tick that ends a game.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_hiscore <= 4'd0;
        end else if (r_game_tick && (w_state_nxt == ST_OVER) && (r_state != ST_OVER) &&
                     (r_score > r_hiscore)) begin
            r_hiscore <= r_score;
        end
    end

    assign hiscore = r_hiscore;
`else
    assign hiscore = 4'h0;
`endif

    assign obs_ack   = r_obs_ack;
    assign game_tick = r_game_tick;
    assign state_o   = r_state;
    assign score     = r_score;
    assign i_select  = r_select;
    assign led_stop  = r_leds[0];
    assign led_run   = r_leds[1];
    assign led_jump  = r_leds[2];
    assign led_duck  = r_leds[3];
    assign led_over  = r_leds[4];

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Bench for dino_game_sequencer with TICK_DIV=4 and two-tick jump/duck.
// Each vector is one game tick: buttons and obstacle are driven right after
// a tick, the expected result is queued, then popped and compared once the
// DUT has updated on the following tick.
module tb_dino_game_sequencer;

`ifdef DINO_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        btn_start, btn_jump, btn_duck;
    logic        obs_valid, obs_type;
    logic        obs_ack, game_tick;
    logic [2:0]  state_o;
    logic [3:0]  score, hiscore;
    logic [11:0] i_select;
    logic        led_stop, led_run, led_jump, led_duck, led_over;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       st, jp, dk, ov, ot;
        logic [2:0] e_state;
        logic [3:0] e_score;
        logic       e_ack;
        logic [3:0] e_hi;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    dino_game_sequencer #(.TICK_DIV(4), .JUMP_TICKS(2), .DUCK_TICKS(2)) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .btn_start(btn_start), .btn_jump(btn_jump), .btn_duck(btn_duck),
        .obs_valid(obs_valid), .obs_type(obs_type), .obs_ack(obs_ack),
        .game_tick(game_tick), .state_o(state_o), .score(score), .hiscore(hiscore),
        .i_select(i_select), .led_stop(led_stop), .led_run(led_run),
        .led_jump(led_jump), .led_duck(led_duck), .led_over(led_over)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [11:0] exp_sel(input logic [2:0] st);
        case (st)
            3'd0:    return 12'h012;
            3'd1:    return 12'hFFF;
            3'd2:    return 12'h345;
            3'd3:    return 12'h678;
            default: return 12'h9AB;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, jp, dk, ov, ot, input logic [2:0] es,
                       input logic [3:0] esc, input logic ea, input logic [3:0] eh);
        vec_t v;
        v.st = st; v.jp = jp; v.dk = dk; v.ov = ov; v.ot = ot;
        v.e_state = es; v.e_score = esc; v.e_ack = ea; v.e_hi = eh;
        vecs.push_back(v);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!game_tick && n < 20);
        if (!game_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: got no game_tick expected one within 20 cycles");
        end
    endtask

    task automatic check_state(input string tag, input vec_t e);
        check({tag, "_state"}, 32'(state_o), 32'(e.e_state));
        check({tag, "_sel"},   32'(i_select), 32'(exp_sel(e.e_state)));
        check({tag, "_score"}, 32'(score), 32'(e.e_score));
        check({tag, "_ack"},   32'(obs_ack), 32'(e.e_ack));
        check({tag, "_leds"},  32'({led_over, led_duck, led_jump, led_run, led_stop}),
              32'(5'b00001 << e.e_state));
        check({tag, "_hi"},    32'(hiscore), HS_EN ? 32'(e.e_hi) : 32'd0);
    endtask

    // Called at the negedge just after a tick update (counter at 1).
    task automatic run_step(input vec_t v);
        vec_t e;
        btn_start = v.st; btn_jump = v.jp; btn_duck = v.dk;
        obs_valid = v.ov; obs_type = v.ot;
        sb_q.push_back(v);
        @(negedge clk_in);
        btn_start = 1'b0; btn_jump = 1'b0; btn_duck = 1'b0;
        check("ack_width", 32'(obs_ack), 32'd0);
        wait_tick();
        @(negedge clk_in);
        check("tick_width", 32'(game_tick), 32'd0);
        e = sb_q.pop_front();
        check_state("vec", e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        logic [3:0] s;
        logic       ack_seen;

        // start, jump+low obstacle, duck+high obstacles, timer expiry with match
        add(1,0,0,0,0, 1, 0,0, 0);
        add(0,1,0,0,0, 2, 0,0, 0);
        add(0,0,0,1,0, 2, 1,1, 0);
        add(0,0,0,0,0, 1, 1,0, 0);
        add(0,0,1,0,0, 3, 1,0, 0);
        add(0,0,0,1,1, 3, 2,1, 0);
        add(0,0,0,1,1, 1, 3,1, 0);
        // obstacle while running -> OVER, restart resets score
        add(0,0,0,1,1, 4, 3,1, 3);
        add(1,0,0,0,0, 0, 3,0, 3);
        add(1,0,0,0,0, 1, 0,0, 3);
        // jump beats duck; duck during JUMP discarded
        add(0,1,1,0,0, 2, 0,0, 3);
        add(0,0,1,0,0, 2, 0,0, 3);
        add(0,0,0,0,0, 1, 0,0, 3);
        add(0,0,0,0,0, 1, 0,0, 3);
        // sixteen cleared obstacles saturate the score
        s = 4'd0;
        for (int k = 0; k < 8; k++) begin
            add(0,1,0,0,0, 2, s,0, 3);
            s = (s == 4'hF) ? 4'hF : s + 4'd1;
            add(0,0,0,1,0, 2, s,1, 3);
            s = (s == 4'hF) ? 4'hF : s + 4'd1;
            add(0,0,0,1,0, 1, s,1, 3);
        end
        add(0,0,0,1,1, 4,15,1,15);
        // obstacles ignored in OVER and IDLE
        add(0,0,0,1,0, 4,15,0,15);
        add(1,0,0,1,0, 0,15,0,15);
        add(1,0,0,1,0, 1, 0,0,15);
        // lower-scoring game leaves the best score alone
        add(0,1,0,0,0, 2, 0,0,15);
        add(0,0,0,1,0, 2, 1,1,15);
        add(0,0,0,1,0, 1, 2,1,15);
        add(0,1,0,0,0, 2, 2,0,15);
        add(0,0,0,1,0, 2, 3,1,15);
        add(0,0,0,0,0, 1, 3,0,15);
        add(0,0,0,1,1, 4, 3,1,15);
        // into DUCK with a nonzero score for the reset case
        add(1,0,0,0,0, 0, 3,0,15);
        add(1,0,0,0,0, 1, 0,0,15);
        add(0,0,1,0,0, 3, 0,0,15);
        add(0,0,0,1,1, 3, 1,1,15);

        reset_n = 1'b0;
        btn_start = 1'b0; btn_jump = 1'b0; btn_duck = 1'b0;
        obs_valid = 1'b0; obs_type = 1'b0;
        repeat (3) @(negedge clk_in);
        r.e_state = 3'd0; r.e_score = 4'd0; r.e_ack = 1'b0; r.e_hi = 4'd0;
        check_state("rst", r);
        check("rst_tick", 32'(game_tick), 32'd0);
        reset_n = 1'b1;
        wait_tick();
        @(negedge clk_in);

        for (int i = 0; i < vecs.size(); i++) run_step(vecs[i]);

        // one-cycle reset in DUCK with a mismatching obstacle held
        obs_valid = 1'b1;
        obs_type  = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk_in);
        reset_n = 1'b1;
        check_state("midrst", r);
        ack_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_in);
            ack_seen = ack_seen | obs_ack;
        end
        check("midrst_no_ack", 32'(ack_seen), 32'd0);
        check("midrst_idle", 32'(state_o), 32'd0);
        obs_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
